partitioned_data_memory: RTL and testbench
==========================================

# partitioned_data_memory

Per-process data memory with a heap region and a stack region for each process; next generation of the single-cycle core's data memory. It adds:
- parametrised width, depth and process count;
- byte-enabled writes;
- a synchronous registered read on the core clock, with a valid flag;
- range/PID fault detection;
- a hardware partition-clear engine that zeroes one process's memory when that process is retired by the scheduler.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits; multiple of 8
- DEPTH, 1024, words per region (heap and stack each) per process
- NPROCESS, 11, number of process partitions
- PID_WIDTH, 32, width of PID ports

Ports:
- clock  in  1  core clock; single clock domain, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- mem_write  in  1  write strobe
- mem_read  in  1  read strobe
- address  in  32 signed  word address; negative selects the stack region, non-negative selects the heap region
- write_data  in  DATA_WIDTH  write word
- byte_en  in  DATA_WIDTH/8  per-byte write enable
- write_pid  in  PID_WIDTH  partition for the write
- read_pid  in  PID_WIDTH  partition for the read
- read_data  out  DATA_WIDTH  registered read word
- read_valid  out  1  read_data valid this cycle
- fault  out  1  one-cycle pulse on a rejected access
- fault_code  out  2  0 none, 1 heap range, 2 stack range, 3 bad PID
- clear_req  in  1  start zeroing partition clear_pid
- clear_pid  in  PID_WIDTH  partition to clear
- clear_busy  out  1  clear engine active
- clear_done  out  1  one-cycle pulse when a clear completes

## Operation
Address decode:
- Heap access: valid when 0 ≤ address < DEPTH; index = pid*DEPTH + address.
- Stack access: valid when −DEPTH ≤ address < 0; index = pid*DEPTH + (DEPTH + address). Address −1 maps to the top word of the stack.
- Index width is clog2(NPROCESS*DEPTH). The offset is computed before truncation so a negative address never wraps into another partition.

Write rules:
- A write with a valid address and pid < NPROCESS updates the bytes whose byte_en bit is set.
- A write with byte_en = 0 is a no-op and is not a fault.

Rejected accesses:
- An invalid address or a pid ≥ NPROCESS rejects the access: no write occurs, and a read returns 0 with read_valid = 1.
- fault = 1 and fault_code is set in the following cycle.
- Fault priority: bad PID over range.
- If both the read and the write fault in the same cycle, the read fault is reported.

Simultaneous read and write:
- Read and write may target different PIDs in the same cycle.
- Same location: read-first; read_data returns the old word.

Clear engine states:
- IDLE: on clear_req, latch clear_pid and go to CLEAR. If clear_pid ≥ NPROCESS, stay in IDLE and pulse fault with code 3.
- CLEAR: counter 0..DEPTH−1 writes zero to heap[pid][cnt] and stack[pid][cnt] each cycle. At cnt = DEPTH−1, go to DONE.
- DONE: clear_done = 1 for one cycle, then IDLE.
- While clear_busy = 1, mem_write and mem_read are ignored: no write, read_valid = 0, no fault. The core stalls on clear_busy.
- clear_req while busy is ignored.

Reset:
- All outputs go to 0; FSM goes to IDLE; counter goes to 0.
- Memory contents are not reset.
- Reset during CLEAR aborts the clear with the partition partially zeroed and no clear_done.

## Timing
- Read latency is 1 cycle: mem_read at edge N gives read_data and read_valid after edge N+1, held one cycle. read_data holds its value when no read occurs.
- A write commits at the edge where mem_write is sampled.
- fault and fault_code are registered and align with the read_valid of the offending access.
- Clear: clear_busy rises the cycle after clear_req, stays high DEPTH+1 cycles (CLEAR plus DONE), and clear_done coincides with the last busy cycle.
- Back-to-back reads every cycle are supported.

## Structure
- Package dmem_pkg: FSM state enum (IDLE, CLEAR, DONE); fault code constants FAULT_NONE, FAULT_HEAP, FAULT_STACK, FAULT_PID; clog2 index-width helper.
- Sub-module dmem_bank: one write port with byte enables, one registered read port, read-first behaviour, depth NPROCESS*DEPTH. Instantiated twice (heap, stack).
- The clear engine muxes onto the bank write ports.

## Test plan
- Write 0xDEADBEEF to heap address 5, pid 2; then read address 5 with pid 2 → 0xDEADBEEF with read_valid one cycle later; read with pid 3 → that partition's content, unaffected.
- Write 0x11223344 at address −1, pid 0, then byte_en 0b0010 with 0xFFFFFFFF → read −1 returns 0x1122FF44; index equals stack[1023].
- Write at address 1024 → fault = 1, code 1, no write. Address −1025 → code 2. pid 11 → code 3; read returns 0 with read_valid = 1.
- Same-cycle read and write to heap address 7, pid 1, old 0xA, new 0xB → read returns 0xA; the next read returns 0xB.
- Fill pid 4 with nonzero data, then clear_req for pid 4 → clear_busy for 1025 cycles, clear_done pulses once, all 2048 words read 0, and pid 5 is unchanged. Issue reads while busy → no read_valid.
- Assert reset_n = 0 at clear cycle 300 → clear_busy = 0 immediately; the next clear_req restarts from counter 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the partitioned data memory.
package dmem_pkg;

  // Clear engine states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  localparam logic [1:0] FAULT_NONE  = 2'd0;
  localparam logic [1:0] FAULT_HEAP  = 2'd1;
  localparam logic [1:0] FAULT_STACK = 2'd2;
  localparam logic [1:0] FAULT_PID   = 2'd3;

  // Width of a bank index covering every partition, at least one bit.
  function automatic int index_width(input int nproc, input int depth);
    int w;
    w = $clog2(nproc * depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/partitioned_data_memory_if.sv
// Core-side bus of the partitioned data memory.
interface partitioned_data_memory_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PID_WIDTH  = 32
) ();
  logic                      mem_write;
  logic                      mem_read;
  logic signed [31:0]        address;
  logic [DATA_WIDTH-1:0]     write_data;
  logic [DATA_WIDTH/8-1:0]   byte_en;
  logic [PID_WIDTH-1:0]      write_pid;
  logic [PID_WIDTH-1:0]      read_pid;
  logic [DATA_WIDTH-1:0]     read_data;
  logic                      read_valid;
  logic                      fault;
  logic [1:0]                fault_code;
  logic                      clear_req;
  logic [PID_WIDTH-1:0]      clear_pid;
  logic                      clear_busy;
  logic                      clear_done;

  modport master (
    output mem_write, mem_read, address, write_data, byte_en,
           write_pid, read_pid, clear_req, clear_pid,
    input  read_data, read_valid, fault, fault_code, clear_busy, clear_done
  );

  modport slave (
    input  mem_write, mem_read, address, write_data, byte_en,
           write_pid, read_pid, clear_req, clear_pid,
    output read_data, read_valid, fault, fault_code, clear_busy, clear_done
  );
endinterface

// File: rtl/dmem_bank.sv
// Single-port-write / single-port-read word bank with byte enables.
// The read register samples before the write lands, giving read-first
// behaviour on a same-address collision. Contents are never reset.
module dmem_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int NWORDS     = 1024,
  parameter int IW         = 10
) (
  input  logic                    clock,
  input  logic                    i_we,
  input  logic [DATA_WIDTH/8-1:0] i_be,
  input  logic [IW-1:0]           i_waddr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic                    i_re,
  input  logic [IW-1:0]           i_raddr,
  output logic [DATA_WIDTH-1:0]   o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [0:NWORDS-1];

  // Registered read (old word) and byte-masked write in the same edge
  always_ff @(posedge clock) begin
    if (i_re) o_rdata <= r_mem[i_raddr];
    if (i_we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (i_be[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end
endmodule

// File: rtl/partitioned_data_memory.sv
// Per-process heap/stack data memory with range/PID fault detection and
// a partition-clear engine that zeroes one process's heap and stack.
//
// state | meaning
// IDLE  | serving core accesses, waiting for clear_req
// CLEAR | writing zero to heap[pid][cnt] and stack[pid][cnt], core stalled
// DONE  | clear_done pulse, last stalled cycle
module partitioned_data_memory
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int NPROCESS   = 11,
  parameter int PID_WIDTH  = 32
) (
  input  logic                      clock,
  input  logic                      reset_n,
  partitioned_data_memory_if.slave  bus
);
  localparam int IW = index_width(NPROCESS, DEPTH);
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = DATA_WIDTH / 8;

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_CLEAR = CLEAR;
  localparam logic [1:0] S_DONE  = DONE;

  localparam logic [1:0] SEL_ZERO  = 2'd0;
  localparam logic [1:0] SEL_HEAP  = 2'd1;
  localparam logic [1:0] SEL_STACK = 2'd2;

  // Offset is formed at full 32-bit width before truncation so a stack
  // address never borrows into the neighbouring partition.
  function automatic logic [IW-1:0] f_index(input logic signed [31:0] a,
                                            input logic [PID_WIDTH-1:0] p);
    logic [31:0] off;
    off = a[31] ? (32'(DEPTH) + a) : a;
    return IW'(p) * IW'(DEPTH) + IW'(off);
  endfunction

  logic [1:0]            r_state;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_clr_pid;
  logic [1:0]            r_rd_sel;
  logic                  r_read_valid;
  logic                  r_fault;
  logic [1:0]            r_fault_code;

  logic                  w_busy, w_clr_we, w_clr_bad;
  logic                  w_in_heap, w_in_stack, w_addr_ok;
  logic                  w_rd_pid_ok, w_wr_pid_ok;
  logic                  w_rd_go, w_rd_ok, w_wr_go, w_wr_ok;
  logic [1:0]            w_rd_code, w_wr_code;
  logic [IW-1:0]         w_rd_idx, w_wr_idx, w_clr_idx, w_waddr;
  logic [BW-1:0]         w_be;
  logic [DATA_WIDTH-1:0] w_wdata, w_heap_rdata, w_stack_rdata;

  assign w_busy    = (r_state != S_IDLE);
  assign w_clr_we  = (r_state == S_CLEAR);
  assign w_clr_bad = (r_state == S_IDLE) && bus.clear_req &&
                     !(bus.clear_pid < PID_WIDTH'(NPROCESS));

  assign w_in_heap  = !bus.address[31] && (bus.address < DEPTH);
  assign w_in_stack =  bus.address[31] && (bus.address >= -DEPTH);
  assign w_addr_ok  = w_in_heap || w_in_stack;

  assign w_rd_pid_ok = (bus.read_pid  < PID_WIDTH'(NPROCESS));
  assign w_wr_pid_ok = (bus.write_pid < PID_WIDTH'(NPROCESS));

  assign w_rd_go = bus.mem_read && !w_busy;
  assign w_rd_ok = w_rd_go && w_rd_pid_ok && w_addr_ok;
  assign w_wr_go = bus.mem_write && !w_busy && (bus.byte_en != '0);
  assign w_wr_ok = w_wr_go && w_wr_pid_ok && w_addr_ok;

  assign w_rd_code = !w_rd_pid_ok ? FAULT_PID :
                     (bus.address[31] ? FAULT_STACK : FAULT_HEAP);
  assign w_wr_code = !w_wr_pid_ok ? FAULT_PID :
                     (bus.address[31] ? FAULT_STACK : FAULT_HEAP);

  assign w_rd_idx  = f_index(bus.address, bus.read_pid);
  assign w_wr_idx  = f_index(bus.address, bus.write_pid);
  assign w_clr_idx = r_clr_pid * IW'(DEPTH) + IW'(r_cnt);

  // Clear engine owns both bank write ports while it runs
  assign w_waddr = w_clr_we ? w_clr_idx : w_wr_idx;
  assign w_be    = w_clr_we ? '1 : bus.byte_en;
  assign w_wdata = w_clr_we ? '0 : bus.write_data;

  dmem_bank #(.DATA_WIDTH(DATA_WIDTH), .NWORDS(NPROCESS*DEPTH), .IW(IW)) u_heap (
    .clock   (clock),
    .i_we    (w_clr_we || (w_wr_ok && !bus.address[31])),
    .i_be    (w_be),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_rd_ok && !bus.address[31]),
    .i_raddr (w_rd_idx),
    .o_rdata (w_heap_rdata)
  );

  dmem_bank #(.DATA_WIDTH(DATA_WIDTH), .NWORDS(NPROCESS*DEPTH), .IW(IW)) u_stack (
    .clock   (clock),
    .i_we    (w_clr_we || (w_wr_ok && bus.address[31])),
    .i_be    (w_be),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_rd_ok && bus.address[31]),
    .i_raddr (w_rd_idx),
    .o_rdata (w_stack_rdata)
  );

  // Clear engine sequencing
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_clr_pid <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.clear_req && !w_clr_bad) begin
            r_state   <= S_CLEAR;
            r_cnt     <= '0;
            r_clr_pid <= IW'(bus.clear_pid);
          end
        end
        S_CLEAR: begin
          if (r_cnt == CW'(DEPTH - 1)) r_state <= S_DONE;
          else                         r_cnt   <= r_cnt + 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read source select and valid; the select holds so read_data holds
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_sel     <= SEL_ZERO;
      r_read_valid <= 1'b0;
    end else begin
      r_read_valid <= w_rd_go;
      if (w_rd_go) begin
        if (!w_rd_ok)             r_rd_sel <= SEL_ZERO;
        else if (bus.address[31]) r_rd_sel <= SEL_STACK;
        else                      r_rd_sel <= SEL_HEAP;
      end
    end
  end

  // Fault pulse: read fault wins over write fault, then bad clear PID
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fault      <= 1'b0;
      r_fault_code <= FAULT_NONE;
    end else begin
      r_fault      <= 1'b0;
      r_fault_code <= FAULT_NONE;
      if (w_rd_go && !w_rd_ok) begin
        r_fault      <= 1'b1;
        r_fault_code <= w_rd_code;
      end else if (w_wr_go && !w_wr_ok) begin
        r_fault      <= 1'b1;
        r_fault_code <= w_wr_code;
      end else if (w_clr_bad) begin
        r_fault      <= 1'b1;
        r_fault_code <= FAULT_PID;
      end
    end
  end

  // Output word mux over the registered bank outputs
  always_comb begin
    bus.read_data = '0;
    case (r_rd_sel)
      SEL_HEAP:  bus.read_data = w_heap_rdata;
      SEL_STACK: bus.read_data = w_stack_rdata;
      default:   bus.read_data = '0;
    endcase
  end

  assign bus.read_valid = r_read_valid;
  assign bus.fault      = r_fault;
  assign bus.fault_code = r_fault_code;
  assign bus.clear_busy = w_busy;
  assign bus.clear_done = (r_state == S_DONE);
endmodule

// File: tb/tb_partitioned_data_memory.sv
// Directed bench for partitioned_data_memory (default parameters).
module tb_partitioned_data_memory;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  partitioned_data_memory_if #(.DATA_WIDTH(32), .PID_WIDTH(32)) bus ();

  partitioned_data_memory #(.DATA_WIDTH(32), .DEPTH(1024), .NPROCESS(11), .PID_WIDTH(32)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input int p, input logic [31:0] d, input logic [3:0] be);
    bus.mem_write  = 1'b1;
    bus.address    = a;
    bus.write_pid  = p;
    bus.write_data = d;
    bus.byte_en    = be;
    @(negedge clk);
    bus.mem_write  = 1'b0;
  endtask

  task automatic rd(input int a, input int p, output logic [31:0] d, output logic v,
                    output logic f, output logic [1:0] c);
    bus.mem_read = 1'b1;
    bus.address  = a;
    bus.read_pid = p;
    @(negedge clk);
    d = bus.read_data; v = bus.read_valid; f = bus.fault; c = bus.fault_code;
    bus.mem_read = 1'b0;
  endtask

  task automatic rw(input int a, input int rp, input int wp, input logic [31:0] wd,
                    input logic [3:0] be, output logic [31:0] d, output logic v,
                    output logic f, output logic [1:0] c);
    bus.mem_read   = 1'b1;
    bus.mem_write  = 1'b1;
    bus.address    = a;
    bus.read_pid   = rp;
    bus.write_pid  = wp;
    bus.write_data = wd;
    bus.byte_en    = be;
    @(negedge clk);
    d = bus.read_data; v = bus.read_valid; f = bus.fault; c = bus.fault_code;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  // Runs one clear of pid p with core reads/writes held high throughout.
  task automatic run_clear(input int p, output int busy_n, output int done_n,
                           output int done_at, output int valid_n, output int fault_n);
    busy_n = 0; done_n = 0; done_at = -1; valid_n = 0; fault_n = 0;
    bus.clear_req = 1'b1;
    bus.clear_pid = p;
    @(negedge clk);
    bus.clear_req  = 1'b0;
    bus.mem_read   = 1'b1;
    bus.mem_write  = 1'b1;
    bus.address    = 0;
    bus.read_pid   = 5;
    bus.write_pid  = 5;
    bus.write_data = 32'hFFFF_FFFF;
    bus.byte_en    = 4'hF;
    while (bus.clear_busy && busy_n < 3000) begin
      if (bus.clear_done) begin done_n++; done_at = busy_n; end
      if (bus.read_valid) valid_n++;
      if (bus.fault) fault_n++;
      busy_n++;
      @(negedge clk);
    end
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic v, f;
    logic [1:0] c;
    int busy_n, done_n, done_at, valid_n, fault_n, bad;

    bus.mem_write = 0; bus.mem_read = 0; bus.address = 0; bus.write_data = 0;
    bus.byte_en = 0; bus.write_pid = 0; bus.read_pid = 0;
    bus.clear_req = 0; bus.clear_pid = 0;
    repeat (2) @(negedge clk);
    chk("rst_read_data", bus.read_data, 0);
    chk("rst_read_valid", bus.read_valid, 0);
    chk("rst_fault", {bus.fault, bus.fault_code}, 0);
    chk("rst_clear", {bus.clear_busy, bus.clear_done}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Heap write/read and partition isolation
    wr(5, 3, 32'h3333_3333, 4'hF);
    wr(5, 2, 32'hDEAD_BEEF, 4'hF);
    rd(5, 2, d, v, f, c);
    chk("heap_rd_data", d, 32'hDEAD_BEEF);
    chk("heap_rd_valid_fault", {v, f}, 2'b10);
    @(negedge clk);
    chk("valid_one_cycle", bus.read_valid, 0);
    chk("read_data_holds", bus.read_data, 32'hDEAD_BEEF);
    rd(5, 3, d, v, f, c);
    chk("heap_other_pid", d, 32'h3333_3333);
    wr(5, 2, 32'h0000_0000, 4'h0);
    chk("be0_no_fault", bus.fault, 0);
    rd(5, 2, d, v, f, c);
    chk("be0_no_write", d, 32'hDEAD_BEEF);

    // Stack top word and byte enables
    wr(-1, 0, 32'h1122_3344, 4'hF);
    wr(-1, 0, 32'hFFFF_FFFF, 4'b0010);
    rd(-1, 0, d, v, f, c);
    chk("stack_byte_en", d, 32'h1122_FF44);
    chk("stack_top_index", dut.u_stack.r_mem[1023], 32'h1122_FF44);
    wr(-1024, 0, 32'h0BAD_F00D, 4'hF);
    chk("stack_bottom_index", dut.u_stack.r_mem[0], 32'h0BAD_F00D);
    rd(-1, 0, d, v, f, c);
    chk("stack_top_intact", d, 32'h1122_FF44);

    // Range and PID faults
    wr(0, 1, 32'h1234_5678, 4'hF);
    wr(-1, 10, 32'hA0A0_A0A0, 4'hF);
    wr(1024, 0, 32'h5555_5555, 4'hF);
    chk("wr_heap_range", {bus.fault, bus.fault_code}, {1'b1, 2'd1});
    @(negedge clk);
    chk("fault_one_cycle", bus.fault, 0);
    rd(0, 1, d, v, f, c);
    chk("heap_range_no_write", d, 32'h1234_5678);
    wr(-1025, 0, 32'h6666_6666, 4'hF);
    chk("wr_stack_range", {bus.fault, bus.fault_code}, {1'b1, 2'd2});
    rd(-1, 10, d, v, f, c);
    chk("stack_range_no_write", d, 32'hA0A0_A0A0);
    wr(0, 11, 32'h7777_7777, 4'hF);
    chk("wr_bad_pid", {bus.fault, bus.fault_code}, {1'b1, 2'd3});
    wr(1024, 0, 32'h5555_5555, 4'h0);
    chk("be0_bad_addr_no_fault", bus.fault, 0);
    rd(5, 11, d, v, f, c);
    chk("rd_bad_pid", {d, v, f, c}, {32'h0, 1'b1, 1'b1, 2'd3});
    rd(1024, 2, d, v, f, c);
    chk("rd_heap_range", {d, v, f, c}, {32'h0, 1'b1, 1'b1, 2'd1});
    rd(2000, 11, d, v, f, c);
    chk("pid_over_range", c, 2'd3);
    rw(-2000, 0, 11, 32'h1, 4'hF, d, v, f, c);
    chk("read_fault_wins", {d, v, f, c}, {32'h0, 1'b1, 1'b1, 2'd2});

    // Same-cycle read and write, read-first, then back-to-back read
    wr(7, 1, 32'hA, 4'hF);
    rw(7, 1, 1, 32'hB, 4'hF, d, v, f, c);
    chk("read_first_old", d, 32'hA);
    rd(7, 1, d, v, f, c);
    chk("back_to_back_new", {d, v}, {32'hB, 1'b1});

    // Bad clear PID
    bus.clear_req = 1'b1; bus.clear_pid = 11;
    @(negedge clk);
    bus.clear_req = 1'b0;
    chk("clr_bad_pid", {bus.clear_busy, bus.fault, bus.fault_code}, {1'b0, 1'b1, 2'd3});

    // Clear pid 4, leaving pid 5 untouched
    for (int i = 0; i < 1024; i++) begin
      wr(i, 4, 32'h4000_0000 | i, 4'hF);
      wr(-1 - i, 4, 32'h4400_0000 | i, 4'hF);
      wr(i, 5, 32'h5000_0000 | i, 4'hF);
      wr(-1 - i, 5, 32'h5500_0000 | i, 4'hF);
    end
    run_clear(4, busy_n, done_n, done_at, valid_n, fault_n);
    chk("clr_busy_cycles", busy_n, 1025);
    chk("clr_done_once", done_n, 1);
    chk("clr_done_last", done_at, 1024);
    chk("clr_no_valid_no_fault", {valid_n, fault_n}, 0);
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      rd(i, 4, d, v, f, c);
      if (d !== 32'h0 || v !== 1'b1) bad++;
      rd(-1 - i, 4, d, v, f, c);
      if (d !== 32'h0 || v !== 1'b1) bad++;
    end
    chk("pid4_nonzero_words", bad, 0);
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      rd(i, 5, d, v, f, c);
      if (d !== (32'h5000_0000 | i)) bad++;
      rd(-1 - i, 5, d, v, f, c);
      if (d !== (32'h5500_0000 | i)) bad++;
    end
    chk("pid5_changed_words", bad, 0);

    // Reset during clear, then restart
    wr(0, 6, 32'h6000_0000, 4'hF);
    wr(299, 6, 32'h6000_0299, 4'hF);
    wr(300, 6, 32'h6000_0300, 4'hF);
    wr(1023, 6, 32'h6000_1023, 4'hF);
    bus.clear_req = 1'b1; bus.clear_pid = 6;
    @(negedge clk);
    bus.clear_req = 1'b0;
    done_n = 0;
    for (int k = 0; k < 300; k++) begin
      if (bus.clear_done) done_n++;
      @(negedge clk);
    end
    chk("abort_busy_before", bus.clear_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy_drop", {bus.clear_busy, bus.clear_done}, 0);
    chk("abort_outputs_zero", {bus.read_data, bus.read_valid, bus.fault}, 0);
    chk("abort_no_done", done_n, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(299, 6, d, v, f, c);
    chk("abort_299_zeroed", d, 32'h0);
    rd(300, 6, d, v, f, c);
    chk("abort_300_kept", d, 32'h6000_0300);
    rd(1023, 6, d, v, f, c);
    chk("abort_1023_kept", d, 32'h6000_1023);
    run_clear(6, busy_n, done_n, done_at, valid_n, fault_n);
    chk("restart_busy_cycles", busy_n, 1025);
    chk("restart_done_once", done_n, 1);
    rd(300, 6, d, v, f, c);
    chk("restart_300_zeroed", d, 32'h0);
    rd(1023, 6, d, v, f, c);
    chk("restart_1023_zeroed", d, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
